// File: rtl/huffman_stream_ctrl_pkg.sv
// rtl/huffman_stream_ctrl_pkg.sv - shared widths and FSM state type for the Huffman stream controller
package huff_pkg;
  localparam int CODE_SIZE = 18;
  localparam int LEN_SIZE  = 5;
  localparam int WORD_SIZE = 8;
  localparam int ERR_W     = 9;
  localparam int CNT_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;
endpackage

// File: rtl/huffman_stream_ctrl_if.sv
// rtl/huffman_stream_ctrl_if.sv - error input, LUT and packed byte output handshakes
interface huffman_stream_ctrl_if import huff_pkg::*; #(
  parameter int code_size = CODE_SIZE,
  parameter int len_size  = LEN_SIZE,
  parameter int word_size = WORD_SIZE
) ();
  logic signed [ERR_W-1:0] err_data;
  logic                    err_valid;
  logic                    err_ready;
  logic [ERR_W-1:0]        lut_error;
  logic [code_size-1:0]    lut_code;
  logic [len_size-1:0]     lut_len;
  logic [word_size-1:0]    byte_out;
  logic                    byte_valid;
  logic                    byte_ready;

  modport master (
    input  err_data, err_valid, lut_code, lut_len, byte_ready,
    output err_ready, lut_error, byte_out, byte_valid
  );

  modport slave (
    output err_data, err_valid, lut_code, lut_len, byte_ready,
    input  err_ready, lut_error, byte_out, byte_valid
  );
endinterface

// File: rtl/huffman_stream_ctrl_acc.sv
// rtl/huffman_stream_ctrl_acc.sv - MSB-first bit accumulator with byte and padded-byte taps
module huff_bit_acc import huff_pkg::*; #(
  parameter int   code_size = CODE_SIZE,
  parameter int   len_size  = LEN_SIZE,
  parameter int   word_size = WORD_SIZE,
  parameter logic pad_bit   = 1'b1,
  localparam int  acc_w     = 2 * code_size,
  localparam int  cnt_bits  = $clog2(acc_w + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 append_en,
  input  logic [code_size-1:0] append_code,
  input  logic [len_size-1:0]  append_len,
  input  logic                 extract_en,
  input  logic                 pad_en,
  output logic [cnt_bits-1:0]  count,
  output logic [word_size-1:0] extract_word,
  output logic [word_size-1:0] pad_word
);
  logic [acc_w-1:0]     buffer;
  logic [acc_w-1:0]     mask;
  logic [acc_w-1:0]     code_ext;
  logic [cnt_bits-1:0]  len_ext;
  logic [cnt_bits-1:0]  pad_shift;
  logic [word_size-1:0] fill_mask;

  always_comb begin
    len_ext      = cnt_bits'(append_len);
    mask         = (acc_w'(1) << len_ext) - acc_w'(1);
    code_ext     = acc_w'(append_code) & mask;
    extract_word = word_size'(buffer >> (count - cnt_bits'(word_size)));
    // Only meaningful while 0 < count < word_size: live bits on top, pad_bit below.
    pad_shift    = cnt_bits'(word_size) - count;
    fill_mask    = ((word_size'(1) << pad_shift) - word_size'(1)) & {word_size{pad_bit}};
    pad_word     = (buffer[word_size-1:0] << pad_shift) | fill_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
      count  <= '0;
    end else if (clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (append_en) begin
      buffer <= (buffer << len_ext) | code_ext;
      count  <= count + len_ext;
    end else if (extract_en) begin
      count <= count - cnt_bits'(word_size);
    end else if (pad_en) begin
      count <= '0;
    end
  end
endmodule

// File: rtl/huffman_stream_ctrl.sv
// rtl/huffman_stream_ctrl.sv - frame sequencer: accepts errors, packs LUT codes, streams bytes
module huffman_stream_ctrl import huff_pkg::*; #(
  parameter int   code_size = CODE_SIZE,
  parameter int   len_size  = LEN_SIZE,
  parameter int   word_size = WORD_SIZE,
  parameter int   cnt_w     = CNT_W,
  parameter logic pad_bit   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [cnt_w-1:0]      num_samples,
  huffman_stream_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w-1:0]      byte_count,
  output logic                  len_err
);
  localparam int cnt_bits = $clog2(2 * code_size + 1);

  state_t               state;
  logic [cnt_w-1:0]     samples_left;
  logic [cnt_bits-1:0]  count;
  logic [word_size-1:0] extract_word;
  logic [word_size-1:0] pad_word;
  logic [len_size-1:0]  sat_len;
  logic len_over, accept, out_free, below_word, extract_en, pad_en, clear;

  assign len_over      = int'(bus.lut_len) > code_size;
  assign sat_len       = len_over ? len_size'(code_size) : bus.lut_len;
  assign out_free      = !bus.byte_valid || bus.byte_ready;
  assign below_word    = count < cnt_bits'(word_size);
  // The below_word gate keeps accept and extract mutually exclusive and bounds the accumulator.
  assign bus.err_ready = (state == ST_RUN) && (samples_left != '0) && below_word;
  assign accept        = bus.err_valid && bus.err_ready;
  assign extract_en    = (state != ST_IDLE) && !below_word && out_free;
  assign pad_en        = (state == ST_FLUSH) && (count != '0) && below_word && out_free;
  assign clear         = (state == ST_IDLE) && start;
  assign bus.lut_error = bus.err_data;

  huff_bit_acc #(
    .code_size (code_size),
    .len_size  (len_size),
    .word_size (word_size),
    .pad_bit   (pad_bit)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .append_en    (accept),
    .append_code  (bus.lut_code),
    .append_len   (sat_len),
    .extract_en   (extract_en),
    .pad_en       (pad_en),
    .count        (count),
    .extract_word (extract_word),
    .pad_word     (pad_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      samples_left   <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      byte_count     <= '0;
      len_err        <= 1'b0;
    end else begin
      if (extract_en) begin
        bus.byte_out   <= extract_word;
        bus.byte_valid <= 1'b1;
      end else if (pad_en) begin
        bus.byte_out   <= pad_word;
        bus.byte_valid <= 1'b1;
      end else if (bus.byte_ready) begin
        bus.byte_valid <= 1'b0;
      end
      if (bus.byte_valid && bus.byte_ready) byte_count <= byte_count + cnt_w'(1);
      if (accept) begin
        samples_left <= samples_left - cnt_w'(1);
        if (len_over) len_err <= 1'b1;
      end
      case (state)
        ST_IDLE: if (start) begin
          samples_left <= num_samples;
          byte_count   <= '0;
          len_err      <= 1'b0;
          busy         <= 1'b1;
          state        <= ST_RUN;
        end
        ST_RUN: if (samples_left == '0 && below_word) state <= ST_FLUSH;
        ST_FLUSH: if (count == '0 && !bus.byte_valid) begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// tb/tb_huffman_stream_ctrl.sv - directed self-checking bench for huffman_stream_ctrl
module tb_huffman_stream_ctrl;
  import huff_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] num_samples;
  logic        busy, done, len_err;
  logic [23:0] byte_count;

  huffman_stream_ctrl_if bus ();

  huffman_stream_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .byte_count  (byte_count),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] got[$];
  int         done_cnt = 0;
  bit         bv_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.byte_valid) bv_seen = 1'b1;
    if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gb(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [23:0] n);
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [8:0] e, input logic [17:0] c, input logic [4:0] l);
    int n = 0;
    bus.err_data  = e;
    bus.lut_code  = c;
    bus.lut_len   = l;
    bus.err_valid = 1'b1;
    @(negedge clk);
    while (!bus.err_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_timeout", 32'(n < 50), 32'd1);
    tick();
    bus.err_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(n < 200), 32'd1);
    check("done_single", done_cnt - d0, 32'd1);
    check("done_low_after", done, 1'b0);
    check("busy_low_after", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0;
    bus.err_data = '0; bus.err_valid = 1'b0; bus.lut_code = '0; bus.lut_len = '0;
    bus.byte_ready = 1'b1;
    tick(); tick();
    check("rst_err_ready", bus.err_ready, 1'b0);
    check("rst_byte_valid", bus.byte_valid, 1'b0);
    check("rst_byte_out", bus.byte_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_byte_count", byte_count, 24'd0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_count", 32'(dut.u_acc.count), 32'd0);
    rst = 1'b0;
    tick();

    // two 8-bit codes, back to back
    got.delete();
    start_frame(24'd2);
    check("t1_busy_rise", busy, 1'b1);
    send(9'h005, 18'h000A5, 5'd8);
    check("t1_lut_error", bus.lut_error, 9'h005);
    check("t1_lat_bv0", bus.byte_valid, 1'b0);
    tick();
    check("t1_lat_bv1", bus.byte_valid, 1'b1);
    check("t1_lat_byte", bus.byte_out, 8'hA5);
    send(9'h1F3, 18'h0003C, 5'd8);
    wait_done();
    check("t1_nbytes", got.size(), 32'd2);
    check("t1_b0", gb(0), 8'hA5);
    check("t1_b1", gb(1), 8'h3C);
    check("t1_byte_count", byte_count, 24'd2);
    check("t1_len_err", len_err, 1'b0);

    // single 3-bit code padded with ones
    got.delete();
    start_frame(24'd1);
    send(9'h001, 18'h00005, 5'd3);
    wait_done();
    check("t2_nbytes", got.size(), 32'd1);
    check("t2_b0", gb(0), 8'hBF);
    check("t2_byte_count", byte_count, 24'd1);

    // three 5-bit codes straddling a byte boundary
    got.delete();
    start_frame(24'd3);
    send(9'h002, 18'h0001F, 5'd5);
    send(9'h003, 18'h00000, 5'd5);
    send(9'h004, 18'h00015, 5'd5);
    wait_done();
    check("t3_nbytes", got.size(), 32'd2);
    check("t3_b0", gb(0), 8'hF8);
    check("t3_b1", gb(1), 8'h2B);
    check("t3_byte_count", byte_count, 24'd2);

    // max-width code under backpressure
    got.delete();
    bus.byte_ready = 1'b0;
    start_frame(24'd1);
    send(9'h1FF, 18'h2AAAA, 5'd18);
    repeat (10) tick();
    check("t4_err_ready_held", bus.err_ready, 1'b0);
    check("t4_bv_held", bus.byte_valid, 1'b1);
    check("t4_byte_held", bus.byte_out, 8'hAA);
    check("t4_no_handoff", got.size(), 32'd0);
    bus.byte_ready = 1'b1;
    wait_done();
    check("t4_nbytes", got.size(), 32'd3);
    check("t4_b0", gb(0), 8'hAA);
    check("t4_b1", gb(1), 8'hAA);
    check("t4_b2", gb(2), 8'hBF);
    check("t4_byte_count", byte_count, 24'd3);

    // oversize length saturates to 18 and flags len_err
    got.delete();
    start_frame(24'd1);
    check("t5_len_err_cleared", len_err, 1'b0);
    send(9'h010, 18'h3FFFF, 5'd20);
    wait_done();
    check("t5_len_err", len_err, 1'b1);
    check("t5_nbytes", got.size(), 32'd3);
    check("t5_b0", gb(0), 8'hFF);
    check("t5_b2", gb(2), 8'hFF);

    // empty frame
    got.delete();
    bv_seen = 1'b0;
    start_frame(24'd0);
    check("t6_busy", busy, 1'b1);
    tick();
    check("t6_done_early", done, 1'b0);
    tick();
    check("t6_done", done, 1'b1);
    tick();
    check("t6_done_fall", done, 1'b0);
    check("t6_busy_fall", busy, 1'b0);
    check("t6_byte_count", byte_count, 24'd0);
    check("t6_bv_never", bv_seen, 1'b0);

    // reset in the middle of a frame with a byte pending
    got.delete();
    bus.byte_ready = 1'b0;
    start_frame(24'd2);
    send(9'h020, 18'h000A5, 5'd8);
    tick();
    check("t7_pre_bv", bus.byte_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t7_rst_bv", bus.byte_valid, 1'b0);
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_count", 32'(dut.u_acc.count), 32'd0);
    check("t7_rst_err_ready", bus.err_ready, 1'b0);
    tick();
    rst = 1'b0;
    bus.byte_ready = 1'b1;
    tick();
    start_frame(24'd1);
    send(9'h021, 18'h0003C, 5'd8);
    wait_done();
    check("t7_nbytes", got.size(), 32'd1);
    check("t7_b0", gb(0), 8'h3C);
    check("t7_byte_count", byte_count, 24'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
